// File: rtl/secded_sweep_controller.sv
// SECDED chain self-test sequencer.
// Steps through every data word (and optionally every noise code), waits
// out the decoder latency, then sorts each decoder result into saturating
// statistics counters that the status logic can read.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | outputs hold; a start request clears stats and launches
// S_DRIVE | present the current vector to the encoder / noise block
// S_WAIT  | let the vector ripple through the datapath (DEC_LAT cycles)
// S_CHECK | sample the decoder, classify, advance or finish
// S_DONE  | one-cycle completion pulse, then back to idle
module secded_sweep_controller #(
  parameter int DEC_LAT = 1,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  output logic [3:0]       enc_data_o,
  output logic [4:0]       noise_o,
  input  logic [3:0]       dec_data_i,
  input  logic             err1_i,
  input  logic             err2_i,
  input  logic             perr_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_det,
  output logic [CNT_W-1:0] cnt_fail,
  output logic [CNT_W-1:0] cnt_perr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0]       LAT_LOAD = 4'(DEC_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [8:0]       LAST_M0  = 9'd15;
  localparam logic [8:0]       LAST_M1  = 9'd511;

  state_t     state;
  state_t     state_nxt;
  logic [8:0] idx;
  logic [3:0] wait_cnt;
  logic       mode_q;
  logic       launch;
  logic       drive_en;
  logic       wait_en;
  logic       check_en;
  logic       last_hit;

  // Counters stick at all-ones so a long soak never reads back as small.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Next state, status outputs and per-state enables; abort overrides all.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    launch    = 1'b0;
    drive_en  = 1'b0;
    wait_en   = 1'b0;
    check_en  = 1'b0;
    last_hit  = (idx == (mode_q ? LAST_M1 : LAST_M0));
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_DRIVE;
          launch    = 1'b1;
        end
      end
      S_DRIVE: begin
        busy      = 1'b1;
        drive_en  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        wait_en = 1'b1;
        if (wait_cnt == 4'd1) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy      = 1'b1;
        check_en  = 1'b1;
        state_nxt = last_hit ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort freezes everything so the partial statistics stay readable.
    if (abort) begin
      state_nxt = S_IDLE;
      launch    = 1'b0;
      drive_en  = 1'b0;
      wait_en   = 1'b0;
      check_en  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Vector index, drive registers, latency timer and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      mode_q     <= 1'b0;
      wait_cnt   <= '0;
      enc_data_o <= '0;
      noise_o    <= '0;
      cnt_ok     <= '0;
      cnt_corr   <= '0;
      cnt_det    <= '0;
      cnt_fail   <= '0;
      cnt_perr   <= '0;
    end else begin
      if (launch) begin
        idx      <= '0;
        mode_q   <= mode;
        cnt_ok   <= '0;
        cnt_corr <= '0;
        cnt_det  <= '0;
        cnt_fail <= '0;
        cnt_perr <= '0;
      end
      if (drive_en) begin
        enc_data_o <= idx[3:0];
        noise_o    <= mode_q ? idx[8:4] : 5'd0;
        wait_cnt   <= LAT_LOAD;
      end
      if (wait_en) wait_cnt <= wait_cnt - 4'd1;
      if (check_en) begin
        // Uncorrectable first, then silent corruption, then corrected.
        if (err2_i)                        cnt_det  <= sat_inc(cnt_det);
        else if (dec_data_i != enc_data_o) cnt_fail <= sat_inc(cnt_fail);
        else if (err1_i)                   cnt_corr <= sat_inc(cnt_corr);
        else                               cnt_ok   <= sat_inc(cnt_ok);
        if (perr_i) cnt_perr <= sat_inc(cnt_perr);
        if (!last_hit) idx <= idx + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_secded_sweep_controller.sv
// Bench for secded_sweep_controller: two instances (DEC_LAT=1/CNT_W=10 and
// DEC_LAT=3/CNT_W=3) share stimulus, each fed by its own pipelined decoder
// model; a sweep-position model predicts every output on every cycle.
module tb_secded_sweep_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, mode;
  int   kind;   // 0 ideal decoder with noise, 1 inverted data, 2 err2 stuck
  int   tests = 0;
  int   fails = 0;

  logic [3:0] enc0, enc1, dd0, dd1;
  logic [4:0] noi0, noi1;
  logic       busy0, busy1, done0, done1;
  logic       e1_0, e1_1, e2_0, e2_1, pe0, pe1;
  logic [9:0] ok0, corr0, det0, fail0, perr0;
  logic [2:0] ok1, corr1, det1, fail1, perr1;

  secded_sweep_controller #(.DEC_LAT(1), .CNT_W(10)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .enc_data_o(enc0), .noise_o(noi0), .dec_data_i(dd0), .err1_i(e1_0),
    .err2_i(e2_0), .perr_i(pe0), .busy(busy0), .done(done0),
    .cnt_ok(ok0), .cnt_corr(corr0), .cnt_det(det0), .cnt_fail(fail0),
    .cnt_perr(perr0));

  secded_sweep_controller #(.DEC_LAT(3), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .enc_data_o(enc1), .noise_o(noi1), .dec_data_i(dd1), .err1_i(e1_1),
    .err2_i(e2_1), .perr_i(pe1), .busy(busy1), .done(done1),
    .cnt_ok(ok1), .cnt_corr(corr1), .cnt_det(det1), .cnt_fail(fail1),
    .cnt_perr(perr1));

  // Decoder behaviour: noise code n flips (n mod 3) bits.
  function automatic logic [6:0] dec_model(input logic [3:0] d, input logic [4:0] n, input int k);
    int nf;
    logic [3:0] dd;
    logic e1, e2, pe;
    nf = int'(n) % 3;
    dd = d; e1 = 1'b0; e2 = 1'b0; pe = 1'b0;
    case (k)
      0: begin
        if (nf == 1) begin e1 = 1'b1; pe = 1'b1; end
        else if (nf == 2) begin e2 = 1'b1; dd = d ^ 4'h1; end
      end
      1: dd = ~d;
      2: e2 = 1'b1;
      default: ;
    endcase
    return {dd, e1, e2, pe};
  endfunction

  logic [6:0] pipe0 [0:15];
  logic [6:0] pipe1 [0:15];

  // Datapath latency: output reflects the vector presented DEC_LAT cycles ago.
  always @(posedge clk) begin
    pipe0[0] <= dec_model(enc0, noi0, kind);
    pipe1[0] <= dec_model(enc1, noi1, kind);
    for (int j = 1; j < 16; j++) begin
      pipe0[j] <= pipe0[j-1];
      pipe1[j] <= pipe1[j-1];
    end
  end
  assign {dd0, e1_0, e2_0, pe0} = pipe0[0];
  assign {dd1, e1_1, e2_1, pe1} = pipe1[2];

  // Reference model: sweep position as a cycle count since launch.
  bit m_act [2];
  bit m_dn  [2];
  bit m_mode[2];
  int m_k   [2];
  int m_enc [2];
  int m_noi [2];
  int m_cnt [2][5];   // ok, corr, det, fail, perr

  function automatic int lat_of(input int i);  return (i == 0) ? 1 : 3;    endfunction
  function automatic int cmax_of(input int i); return (i == 0) ? 1023 : 7; endfunction
  function automatic int sat(input int x, input int mx); return (x < mx) ? x + 1 : x; endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int p, v, ph, lst;
    logic [6:0] r;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_dn[i] = 0; m_mode[i] = 0; m_k[i] = 0; m_enc[i] = 0; m_noi[i] = 0;
        for (int c = 0; c < 5; c++) m_cnt[i][c] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        p = lat_of(i) + 2;
        if (abort) begin
          m_act[i] = 0; m_dn[i] = 0;
        end else if (m_dn[i]) begin
          m_dn[i] = 0;
        end else if (!m_act[i]) begin
          if (start) begin
            m_act[i] = 1; m_k[i] = 0; m_mode[i] = mode;
            for (int c = 0; c < 5; c++) m_cnt[i][c] = 0;
          end
        end else begin
          v   = m_k[i] / p;
          ph  = m_k[i] % p;
          lst = m_mode[i] ? 511 : 15;
          if (ph == 0) begin
            m_enc[i] = v % 16;
            m_noi[i] = m_mode[i] ? v / 16 : 0;
          end
          if (ph == p - 1) begin
            r = dec_model(4'(v % 16), m_mode[i] ? 5'(v / 16) : 5'd0, kind);
            if (r[1])                       m_cnt[i][2] = sat(m_cnt[i][2], cmax_of(i));
            else if (int'(r[6:3]) != v % 16) m_cnt[i][3] = sat(m_cnt[i][3], cmax_of(i));
            else if (r[2])                  m_cnt[i][1] = sat(m_cnt[i][1], cmax_of(i));
            else                            m_cnt[i][0] = sat(m_cnt[i][0], cmax_of(i));
            if (r[0]) m_cnt[i][4] = sat(m_cnt[i][4], cmax_of(i));
            if (v == lst) begin m_act[i] = 0; m_dn[i] = 1; end
            else m_k[i] = m_k[i] + 1;
          end else begin
            m_k[i] = m_k[i] + 1;
          end
        end
      end
    end
  end

  string sn [0:8] = '{"enc", "noise", "busy", "done", "cnt_ok", "cnt_corr", "cnt_det", "cnt_fail", "cnt_perr"};

  function automatic int dut_val(input int i, input int s);
    if (i == 0) begin
      case (s)
        0: return int'(enc0);  1: return int'(noi0);  2: return int'(busy0);
        3: return int'(done0); 4: return int'(ok0);   5: return int'(corr0);
        6: return int'(det0);  7: return int'(fail0); 8: return int'(perr0);
        default: return -1;
      endcase
    end
    case (s)
      0: return int'(enc1);  1: return int'(noi1);  2: return int'(busy1);
      3: return int'(done1); 4: return int'(ok1);   5: return int'(corr1);
      6: return int'(det1);  7: return int'(fail1); 8: return int'(perr1);
      default: return -1;
    endcase
  endfunction

  function automatic int model_val(input int i, input int s);
    case (s)
      0: return m_enc[i];
      1: return m_noi[i];
      2: return int'(m_act[i]);
      3: return int'(m_dn[i]);
      default: return m_cnt[i][s-4];
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++)
        for (int s = 0; s < 9; s++)
          chk($sformatf("u%0d_%s", i, sn[s]), dut_val(i, s), model_val(i, s));
    end
  end

  task automatic run_sweep(input bit md, input int knd, input int budget,
                           output int busy_cyc, output int dn0, output int dn1);
    bit finished;
    kind = knd; mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0; dn0 = 0; dn1 = 0; finished = 0;
    for (int n = 0; n < budget; n++) begin
      if (busy0) busy_cyc++;
      if (done0) dn0++;
      if (done1) dn1++;
      if (dn0 > 0 && dn1 > 0 && !done0 && !done1) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    chk("sweep_finished_in_budget", int'(finished), 1);
  endtask

  int bc, d0, d1, nd;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; kind = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 9; s++)
        chk($sformatf("reset_u%0d_%s", i, sn[s]), dut_val(i, s), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0, ideal decoder.
    run_sweep(1'b0, 0, 200, bc, d0, d1);
    chk("m0_busy_cycles", bc, 48);
    chk("m0_done_pulses_u0", d0, 1);
    chk("m0_done_pulses_u1", d1, 1);
    chk("m0_u0_ok", int'(ok0), 16);
    chk("m0_u0_not_ok", int'(corr0) + int'(det0) + int'(fail0) + int'(perr0), 0);
    chk("m0_u1_ok_sat", int'(ok1), 7);
    chk("m0_model_ok", m_cnt[0][0], 16);

    // Mode 1, noise flips 0/1/2 bits.
    run_sweep(1'b1, 0, 3000, bc, d0, d1);
    chk("m1_u0_ok", int'(ok0), 176);
    chk("m1_u0_corr", int'(corr0), 176);
    chk("m1_u0_det", int'(det0), 160);
    chk("m1_u0_fail", int'(fail0), 0);
    chk("m1_u0_perr", int'(perr0), 176);
    chk("m1_u0_total", int'(ok0) + int'(corr0) + int'(det0) + int'(fail0), 512);
    chk("m1_u1_corr_sat", int'(corr1), 7);
    chk("m1_model_corr", m_cnt[0][1], 176);
    chk("m1_model_det", m_cnt[0][2], 160);

    // Inverted decoder data.
    run_sweep(1'b0, 1, 200, bc, d0, d1);
    chk("inv_u0_fail", int'(fail0), 16);
    chk("inv_u0_ok", int'(ok0), 0);
    chk("inv_u1_fail_sat", int'(fail1), 7);

    // err2 stuck high, mode 1: 3-bit counter must stick at 7.
    run_sweep(1'b1, 2, 3000, bc, d0, d1);
    chk("det_u1_sat", int'(det1), 7);
    chk("det_u1_others", int'(ok1) + int'(corr1) + int'(fail1) + int'(perr1), 0);
    chk("det_u0_count", int'(det0), 512);

    // Abort during the fifth CHECK of u0.
    kind = 0; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_u0", int'(busy0), 0);
    chk("abort_busy_u1", int'(busy1), 0);
    chk("abort_u0_ok", int'(ok0), 4);
    chk("abort_u1_ok", int'(ok1), 2);
    nd = 0;
    for (int n = 0; n < 5; n++) begin
      if (done0 || done1) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);
    chk("abort_u0_ok_held", int'(ok0), 4);

    // Restart clears, then reset mid-WAIT of u1.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_u0_cleared", int'(ok0), 0);
    chk("restart_u1_cleared", int'(ok1), 0);
    repeat (12) @(negedge clk);
    chk("pre_reset_u0_enc", int'(enc0), 3);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 9; s++)
        chk($sformatf("midrst_u%0d_%s", i, sn[s]), dut_val(i, s), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomised start/abort/mode, kind changed only while idle.
    for (int n = 0; n < 4000; n++) begin
      if (!m_act[0] && !m_act[1] && !m_dn[0] && !m_dn[1] && $urandom_range(0, 3) == 0)
        kind = int'($urandom_range(0, 2));
      start = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 149) == 0);
      mode  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
